// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the 32-bit-CPU-to-16-bit-SRAM bridge.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_WAIT_CYCLES = 2;
  localparam logic [31:0] DEF_BASE_ADDR   = 32'd1024;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Counts the cycles of one SRAM halfword access; tc marks the last cycle.
module sram_wait_counter
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(WAIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == TC_VAL);

  // Wraps to zero on terminal count so HI starts fresh straight after LO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit CPU load/store into two timed 16-bit SRAM accesses and
// freezes the pipeline (ready low) until the pair completes.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  input  logic [SRAM_DATA_W-1:0] sram_dq_i,
  output logic [SRAM_DATA_W-1:0] sram_dq_o,
  output logic                   sram_dq_oe,
  output logic                   sram_we_n
);

  state_t      state;
  logic        op_wr;
  logic [16:0] word_q;
  logic [31:0] wdata_q;
  logic        req;
  logic        cnt_clr;
  logic        cnt_en;
  logic        cnt_tc;
  logic [31:0] off;
  logic        unused_off_bits;

  assign req             = wr_en | rd_en;
  assign off             = address - BASE_ADDR;
  assign unused_off_bits = ^{off[31:19], off[1:0]};

  assign cnt_clr = (state == ST_IDLE);
  assign cnt_en  = (state == ST_LO) || (state == ST_HI);

  assign ready = ((state == ST_IDLE) && !req) || (state == ST_DONE);

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .en (cnt_en),
    .tc (cnt_tc)
  );

  // SRAM pins are registered alongside the state so they change on the same
  // edge as the state they belong to and drop to safe values on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_wr      <= 1'b0;
      word_q     <= '0;
      wdata_q    <= '0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state      <= ST_LO;
            op_wr      <= wr_en;
            word_q     <= off[18:2];
            wdata_q    <= write_data;
            sram_addr  <= {off[18:2], 1'b0};
            sram_dq_o  <= wr_en ? write_data[15:0] : '0;
            sram_dq_oe <= wr_en;
            sram_we_n  <= ~wr_en;
          end
        end
        ST_LO: begin
          if (cnt_tc) begin
            if (!op_wr) begin
              read_data[15:0] <= sram_dq_i;
            end
            state     <= ST_HI;
            sram_addr <= {word_q, 1'b1};
            sram_dq_o <= op_wr ? wdata_q[31:16] : '0;
          end
        end
        ST_HI: begin
          if (cnt_tc) begin
            if (!op_wr) begin
              read_data[31:16] <= sram_dq_i;
            end
            state      <= ST_DONE;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, clock cycles per 16-bit SRAM access (legal range 1..15).
REQ-002 SHALL have parameter BASE_ADDR, default 32'd1024, CPU byte address that maps to SRAM word 0.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port wr_en  input  1  write request from the memory stage.
REQ-006 SHALL have port rd_en  input  1  read request from the memory stage.
REQ-007 SHALL have port address  input  32  CPU byte address (ALU result).
REQ-008 SHALL have port write_data  input  32  store data (Val_Rm).
REQ-009 SHALL have port read_data  output  32  load result returned to the memory stage.
REQ-010 SHALL have port ready  output  1  high = the pipeline may advance; low = freeze.
REQ-011 SHALL have port sram_addr  output  18  SRAM halfword address.
REQ-012 SHALL have port sram_dq_i  input  16  SRAM data in.
REQ-013 SHALL have port sram_dq_o  output  16  SRAM data out.
REQ-014 SHALL have port sram_dq_oe  output  1  high = drive sram_dq_o onto the bus.
REQ-015 SHALL have port sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-016 Address map: off = address - BASE_ADDR (32-bit, wraps modulo 2^32); sram_addr = {off[18:2], half}, half = 0 for bits [15:0] and 1 for bits [31:16]; address[1:0] ignored.
REQ-017 States: IDLE, LO, HI, DONE.
REQ-018 IDLE with wr_en or rd_en high: latch address, write_data and op (write wins when both are high), clear the wait counter, go to LO.
REQ-019 LO and HI each last exactly WAIT_CYCLES cycles, counted by the wait counter; LO then goes to HI, HI then goes to DONE.
REQ-020 Write op: in LO drive half 0 with write_data[15:0]; in HI drive half 1 with write_data[31:16]; sram_dq_oe=1 and sram_we_n=0 in both states.
REQ-021 Read op: sram_dq_oe=0 and sram_we_n=1; sample sram_dq_i in the last cycle of LO into read_data[15:0] and in the last cycle of HI into read_data[31:16].
REQ-022 DONE lasts one cycle, ignores requests, then goes to IDLE; a request still asserted is accepted in IDLE as a new access.
REQ-023 ready = (IDLE and no request) or DONE; combinational from state and request.
REQ-024 Latency: a request accepted on edge 0 has ready high during cycle 2*WAIT_CYCLES+1, and read_data is valid in that cycle.
REQ-025 Latched op and address SHALL be used throughout; request deassertion mid-access does not abort it.
REQ-026 read_data holds its value until the next read overwrites it; writes leave it unchanged.
REQ-027 Outside LO/HI: sram_we_n=1, sram_dq_oe=0, sram_dq_o=0, sram_addr=0.

Reset
REQ-028 rst low SHALL immediately force state IDLE, wait counter 0, read_data 0, latches 0, sram_we_n=1, sram_dq_oe=0, including during LO/HI.
REQ-029 With rst low, ready SHALL follow the IDLE rule; the first access is accepted on the first edge after rst rises.

Structure
REQ-030 Shared package SHALL hold the state enum, the WAIT_CYCLES and BASE_ADDR defaults, and the SRAM width constants (18 address, 16 data).
REQ-031 The wait counter SHALL be a sub-module sram_wait_counter (clear, enable, terminal-count output).

Verification
REQ-032 WAIT_CYCLES=2, write 0x12345678 at address 1024: sram_addr 0 gets 0x5678 with sram_we_n low for 2 cycles, then sram_addr 1 gets 0x1234; ready high in cycle 5 only.
REQ-033 Read back from address 1024 with the SRAM model: read_data = 0x12345678 in cycle 5; ready low in cycles 0-4.
REQ-034 Access at address 1034: sram_addr 4 then 5 (bits [1:0] ignored).
REQ-035 wr_en and rd_en both high: write performed, read_data unchanged.
REQ-036 rst pulsed low in cycle 2 of a write: sram_we_n=1 and sram_dq_oe=0 at once, state IDLE; the next read completes normally.
REQ-037 Idle with no request: ready=1, sram_we_n=1, and no SRAM activity for 20 cycles.
